// File: rtl/clk_div_ratio_ctrl.sv
// Run/stop and ratio-change sequencer for a counter-based clock divider.
// Start, stop and ratio changes take effect only on a divided-period boundary,
// so the divided clock never produces a runt pulse.
module clk_div_ratio_ctrl #(
    parameter int unsigned RATIO_W       = 4,
    parameter int unsigned DEFAULT_RATIO = 7,
    parameter int unsigned MIN_RATIO     = 2,
    parameter int unsigned SETTLE_CYC    = 2,
    parameter int unsigned DRAIN_MAX     = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [RATIO_W-1:0] i_req_ratio,
    input  logic               i_div_count_end,
    output logic               o_div_clk_en,
    output logic               o_div_count_valid,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_div_load,
    output logic               o_busy,
    output logic [2:0]         o_state,
    output logic               o_err_ratio,
    output logic               o_err_timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    // One counter serves both the DRAIN timeout and the SETTLE hold.
    localparam int unsigned CNT_W = $clog2(DRAIN_MAX + SETTLE_CYC + 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_flag_q, run_flag_d;
    logic               pend_vld_q, pend_vld_d;
    logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
    logic               en_q, en_d;
    logic               load_q, load_d;
    logic               busy_q, busy_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               err_ratio_q, err_ratio_d;
    logic               err_to_q, err_to_d;

    logic               xfer;
    logic               req_bad;
    logic               req_take;
    logic               drain_exit;

    // Requests are accepted only while the divider is stable and nothing is queued.
    always_comb begin
        o_req_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !pend_vld_q;
    end

    // Next-state, pending-request and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_flag_d   = run_flag_q;
        pend_vld_d   = pend_vld_q;
        pend_ratio_d = pend_ratio_q;
        err_ratio_d  = 1'b0;
        err_to_d     = 1'b0;

        xfer       = i_req_valid && o_req_ready;
        req_bad    = i_req_ratio < RATIO_W'(MIN_RATIO);
        req_take   = xfer && !req_bad && (i_req_ratio != ratio_q);
        drain_exit = i_div_count_end || (cnt_q == CNT_W'(DRAIN_MAX - 1));

        // Stop has priority over a same-edge start.
        if (i_start) begin
            run_flag_d = 1'b1;
        end
        if (i_stop) begin
            run_flag_d = 1'b0;
        end

        if (xfer && req_bad) begin
            err_ratio_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_take) begin
                    pend_vld_d   = 1'b1;
                    pend_ratio_d = i_req_ratio;
                    state_d      = ST_LOAD;
                end else if (run_flag_d) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_take) begin
                    pend_vld_d   = 1'b1;
                    pend_ratio_d = i_req_ratio;
                    state_d      = ST_DRAIN;
                end
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_exit) begin
                    err_to_d = !i_div_count_end;
                    if (pend_vld_q) begin
                        state_d = ST_LOAD;
                    end else if (run_flag_d) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                pend_vld_d = 1'b0;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = run_flag_d ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count only in the timed states; restart on every state change.
        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_RUN)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        en_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        load_d  = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_DRAIN) || (state_d == ST_LOAD) || (state_d == ST_SETTLE);
        ratio_d = ((state_d == ST_LOAD) && (state_q != ST_LOAD)) ? pend_ratio_d : ratio_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            run_flag_q   <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_ratio_q <= '0;
            en_q         <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            ratio_q      <= RATIO_W'(DEFAULT_RATIO);
            err_ratio_q  <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_flag_q   <= run_flag_d;
            pend_vld_q   <= pend_vld_d;
            pend_ratio_q <= pend_ratio_d;
            en_q         <= en_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            ratio_q      <= ratio_d;
            err_ratio_q  <= err_ratio_d;
            err_to_q     <= err_to_d;
        end
    end

    assign o_div_clk_en      = en_q;
    assign o_div_count_valid = en_q;
    assign o_div_ratio       = ratio_q;
    assign o_div_load        = load_q;
    assign o_busy            = busy_q;
    assign o_state           = state_q;
    assign o_err_ratio       = err_ratio_q;
    assign o_err_timeout     = err_to_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Self-checking bench for clk_div_ratio_ctrl: directed scenarios plus a
// randomized request/stop sequence checked against a timeline model.
module tb_clk_div_ratio_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_DRAIN  = 2;
    localparam int S_LOAD   = 3;
    localparam int S_SETTLE = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic [3:0] i_req_ratio = 4'd0;
    logic       i_div_count_end = 1'b0;
    logic       o_div_clk_en;
    logic       o_div_count_valid;
    logic [3:0] o_div_ratio;
    logic       o_div_load;
    logic       o_busy;
    logic [2:0] o_state;
    logic       o_err_ratio;
    logic       o_err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_ratio = 7;

    clk_div_ratio_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .i_start           (i_start),
        .i_stop            (i_stop),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_ratio       (i_req_ratio),
        .i_div_count_end   (i_div_count_end),
        .o_div_clk_en      (o_div_clk_en),
        .o_div_count_valid (o_div_count_valid),
        .o_div_ratio       (o_div_ratio),
        .o_div_load        (o_div_load),
        .o_busy            (o_busy),
        .o_state           (o_state),
        .o_err_ratio       (o_err_ratio),
        .o_err_timeout     (o_err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (int'(o_state) !== S_IDLE || o_div_ratio !== 4'd7) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d ratio=%0d, expected state=0 ratio=7", o_state, o_div_ratio);
        end
        n_checks++;
        if ({o_div_clk_en, o_div_count_valid, o_div_load, o_busy, o_err_ratio, o_err_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: en/valid/load/busy/eratio/eto=%b expected 000000",
                     {o_div_clk_en, o_div_count_valid, o_div_load, o_busy, o_err_ratio, o_err_timeout});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        i_req_valid = 1'b1;
        i_req_ratio = 4'd1;
        n_checks++;
        if (o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_ready: got %b expected 1", o_req_ready);
        end
        tick();
        i_req_valid = 1'b0;
        n_checks++;
        if (o_err_ratio !== 1'b1 || int'(o_state) !== S_IDLE || o_div_ratio !== 4'd7) begin
            n_fail++;
            $display("FAIL illegal_err: err=%b state=%0d ratio=%0d expected err=1 state=0 ratio=7",
                     o_err_ratio, o_state, o_div_ratio);
        end
        tick();
        n_checks++;
        if (o_err_ratio !== 1'b0 || int'(o_state) !== S_IDLE) begin
            n_fail++;
            $display("FAIL illegal_pulse: err=%b state=%0d expected err=0 state=0", o_err_ratio, o_state);
        end
    endtask

    task automatic test_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (o_div_clk_en !== 1'b1 || o_div_count_valid !== 1'b1 || int'(o_state) !== S_RUN
            || o_div_ratio !== 4'd7) begin
            n_fail++;
            $display("FAIL start: en=%b valid=%b state=%0d ratio=%0d expected 1 1 1 7",
                     o_div_clk_en, o_div_count_valid, o_state, o_div_ratio);
        end
    endtask

    task automatic test_ratio_change();
        int dc;
        int rdy_bad;
        dc = 0;
        rdy_bad = 0;
        i_req_valid = 1'b1;
        i_req_ratio = 4'd5;
        tick();
        i_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (int'(o_state) == S_DRAIN && o_div_clk_en === 1'b1) dc++;
            if (o_req_ready !== 1'b0) rdy_bad++;
            if (i == 9) i_div_count_end = 1'b1;
            tick();
        end
        i_div_count_end = 1'b0;
        n_checks++;
        if (dc != 10) begin
            n_fail++;
            $display("FAIL change_drain_len: got %0d drain cycles expected 10", dc);
        end
        n_checks++;
        if (int'(o_state) !== S_LOAD || o_div_load !== 1'b1 || o_div_ratio !== 4'd5
            || o_div_clk_en !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL change_load: state=%0d load=%b ratio=%0d en=%b busy=%b expected 3 1 5 0 1",
                     o_state, o_div_load, o_div_ratio, o_div_clk_en, o_busy);
        end
        for (int i = 0; i < 2; i++) begin
            if (o_req_ready !== 1'b0) rdy_bad++;
            tick();
            n_checks++;
            if (int'(o_state) !== S_SETTLE || o_div_load !== 1'b0 || o_div_clk_en !== 1'b0) begin
                n_fail++;
                $display("FAIL change_settle%0d: state=%0d load=%b en=%b expected 4 0 0",
                         i, o_state, o_div_load, o_div_clk_en);
            end
        end
        if (o_req_ready !== 1'b0) rdy_bad++;
        tick();
        n_checks++;
        if (int'(o_state) !== S_RUN || o_div_clk_en !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL change_resume: state=%0d en=%b busy=%b expected 1 1 0", o_state, o_div_clk_en, o_busy);
        end
        n_checks++;
        if (rdy_bad != 0) begin
            n_fail++;
            $display("FAIL change_ready: ready high in %0d busy cycles expected 0", rdy_bad);
        end
        cur_ratio = 5;
    endtask

    task automatic test_stop_and_req();
        i_stop = 1'b1;
        i_req_valid = 1'b1;
        i_req_ratio = 4'd3;
        tick();
        i_stop = 1'b0;
        i_req_valid = 1'b0;
        n_checks++;
        if (int'(o_state) !== S_DRAIN) begin
            n_fail++;
            $display("FAIL stopreq_drain: state=%0d expected 2", o_state);
        end
        tick();
        i_div_count_end = 1'b1;
        tick();
        i_div_count_end = 1'b0;
        n_checks++;
        if (int'(o_state) !== S_LOAD || o_div_ratio !== 4'd3 || o_div_load !== 1'b1) begin
            n_fail++;
            $display("FAIL stopreq_load: state=%0d ratio=%0d load=%b expected 3 3 1", o_state, o_div_ratio, o_div_load);
        end
        tick();
        tick();
        n_checks++;
        if (int'(o_state) !== S_SETTLE) begin
            n_fail++;
            $display("FAIL stopreq_settle: state=%0d expected 4", o_state);
        end
        tick();
        n_checks++;
        if (int'(o_state) !== S_IDLE || o_div_clk_en !== 1'b0 || o_div_count_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stopreq_idle: state=%0d en=%b valid=%b busy=%b expected 0 0 0 0",
                     o_state, o_div_clk_en, o_div_count_valid, o_busy);
        end
        cur_ratio = 3;
    endtask

    task automatic test_timeout();
        int dc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_req_valid = 1'b1;
        i_req_ratio = 4'd9;
        tick();
        i_req_valid = 1'b0;
        dc = 0;
        while (int'(o_state) == S_DRAIN && dc < 200) begin
            if (o_err_timeout !== 1'b0) dc = 1000;
            dc++;
            tick();
        end
        n_checks++;
        if (dc != 64) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d drain cycles expected 64", dc);
        end
        n_checks++;
        if (o_err_timeout !== 1'b1 || int'(o_state) !== S_LOAD || o_div_ratio !== 4'd9) begin
            n_fail++;
            $display("FAIL timeout_pulse: eto=%b state=%0d ratio=%0d expected 1 3 9", o_err_timeout, o_state, o_div_ratio);
        end
        tick();
        n_checks++;
        if (o_err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_width: eto=%b expected 0", o_err_timeout);
        end
        tick();
        tick();
        n_checks++;
        if (int'(o_state) !== S_RUN) begin
            n_fail++;
            $display("FAIL timeout_resume: state=%0d expected 1", o_state);
        end
        cur_ratio = 9;
    endtask

    // Expected per-cycle state timeline derived from the sequencing rules.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int r, d, fin;
            bit stp, bad, chg;
            int exp_q[$];
            r   = int'($urandom_range(0, 15));
            d   = int'($urandom_range(1, 12));
            stp = ($urandom_range(0, 3) == 0);
            bad = (r < 2);
            chg = !bad && (r != cur_ratio);
            exp_q.delete();
            if (chg || stp) begin
                for (int k = 0; k < d; k++) exp_q.push_back(S_DRAIN);
            end
            if (chg) begin
                exp_q.push_back(S_LOAD);
                exp_q.push_back(S_SETTLE);
                exp_q.push_back(S_SETTLE);
            end
            fin = stp ? S_IDLE : S_RUN;

            n_checks++;
            if (o_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_ready it=%0d: got %b expected 1", it, o_req_ready);
            end
            i_req_valid = 1'b1;
            i_req_ratio = 4'(r);
            i_stop = stp;
            tick();
            i_req_valid = 1'b0;
            i_stop = 1'b0;
            n_checks++;
            if (o_err_ratio !== bad) begin
                n_fail++;
                $display("FAIL rand_err it=%0d: got %b expected %b (ratio %0d)", it, o_err_ratio, bad, r);
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (int'(o_state) !== exp_q[k]
                    || o_div_clk_en !== (exp_q[k] == S_RUN || exp_q[k] == S_DRAIN)
                    || o_div_load !== (exp_q[k] == S_LOAD)) begin
                    n_fail++;
                    $display("FAIL rand_seq it=%0d k=%0d: state=%0d en=%b load=%b expected state %0d",
                             it, k, o_state, o_div_clk_en, o_div_load, exp_q[k]);
                end
                if (exp_q[k] == S_DRAIN) i_div_count_end = (k == d - 1);
                else i_div_count_end = 1'($urandom_range(0, 1));
                tick();
            end
            i_div_count_end = 1'b0;
            if (chg) cur_ratio = r;
            n_checks++;
            if (int'(o_state) !== fin || int'(o_div_ratio) !== cur_ratio) begin
                n_fail++;
                $display("FAIL rand_final it=%0d: state=%0d ratio=%0d expected %0d %0d",
                         it, o_state, o_div_ratio, fin, cur_ratio);
            end
            if (fin == S_IDLE) begin
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                n_checks++;
                if (int'(o_state) !== S_RUN) begin
                    n_fail++;
                    $display("FAIL rand_restart it=%0d: state=%0d expected 1", it, o_state);
                end
            end
        end
    endtask

    task automatic test_reset_in_settle();
        i_req_valid = 1'b1;
        i_req_ratio = (cur_ratio == 9) ? 4'd10 : 4'd9;
        tick();
        i_req_valid = 1'b0;
        i_div_count_end = 1'b1;
        tick();
        i_div_count_end = 1'b0;
        tick();
        n_checks++;
        if (int'(o_state) !== S_SETTLE) begin
            n_fail++;
            $display("FAIL rst_settle_reach: state=%0d expected 4", o_state);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (int'(o_state) !== S_IDLE || o_div_ratio !== 4'd7 || o_busy !== 1'b0
            || o_div_clk_en !== 1'b0 || o_div_load !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_settle_async: state=%0d ratio=%0d busy=%b en=%b load=%b expected 0 7 0 0 0",
                     o_state, o_div_ratio, o_busy, o_div_clk_en, o_div_load);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        n_checks++;
        if (int'(o_state) !== S_IDLE || o_div_clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_settle_after: state=%0d en=%b expected 0 0 (run flag cleared)", o_state, o_div_clk_en);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_illegal();
        test_start();
        test_ratio_change();
        test_stop_and_req();
        test_timeout();
        test_random();
        test_reset_in_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
